// File: rtl/onchip_mem_byte_streamer_if.sv
// Bundles the memory read port, the Avalon-ST byte source and the transfer
// control/status lines of the on-chip memory byte streamer.
// master: the streamer itself. slave: the environment (memory, sink, controller).
interface onchip_mem_byte_streamer_if #(
    parameter int ADDR_W = 16
);
    // Transfer control / status
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;

    // On-chip memory read port
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic              mem_write;
    logic [7:0]        mem_readdata;

    // Avalon-ST byte source
    logic [7:0]        st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_startofpacket;
    logic              st_endofpacket;

    modport master (
        input  start, base_addr, length, mem_readdata, st_ready,
        output busy, done, mem_address, mem_chipselect, mem_clken, mem_write,
               st_data, st_valid, st_startofpacket, st_endofpacket
    );

    modport slave (
        output start, base_addr, length, mem_readdata, st_ready,
        input  busy, done, mem_address, mem_chipselect, mem_clken, mem_write,
               st_data, st_valid, st_startofpacket, st_endofpacket
    );
endinterface

// File: rtl/onchip_mem_byte_streamer.sv
// Reads a run of bytes from an on-chip memory (1-cycle read latency) and
// streams them out as a single Avalon-ST packet through a small skid FIFO.
// Reads are only issued when the FIFO is guaranteed to have room for the
// returning byte, so returning data is written without any back-pressure.
module onchip_mem_byte_streamer #(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    onchip_mem_byte_streamer_if.master    bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   len_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [CNT_W:0]    occ_t;

    localparam occ_t DEPTH_OCC = occ_t'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t state_reg;
    addr_t  addr_reg;        // next address to read
    len_t   issue_left_reg;  // reads still to be issued
    len_t   len_reg;         // packet length, for EOP marking
    len_t   out_idx_reg;     // index of the byte at the FIFO head
    logic   inflight_reg;    // a read was issued last cycle
    ptr_t   wr_ptr_reg;
    ptr_t   rd_ptr_reg;
    cnt_t   count_reg;
    logic   busy_reg;
    logic   done_reg;

    logic [7:0] slot_data [FIFO_DEPTH];

    occ_t occupancy;
    logic issue;
    logic push;
    logic pop;
    logic fifo_valid;
    logic last_byte;
    logic sop;
    logic eop;

    // Space check counts the byte already on its way back from memory.
    assign occupancy  = occ_t'(count_reg) + occ_t'(inflight_reg);
    assign issue      = (state_reg == RUN) && (occupancy < DEPTH_OCC);
    assign push       = inflight_reg;
    assign fifo_valid = (count_reg != '0);
    assign pop        = fifo_valid && bus.st_ready;
    assign last_byte  = (out_idx_reg == len_t'(len_reg - len_t'(1)));
    assign sop        = fifo_valid && (out_idx_reg == '0);
    assign eop        = fifo_valid && last_byte;

    // FIFO storage: one byte register per slot, written from the read return.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            logic [7:0] slot_reg;

            // Capture returning memory data into the slot the write pointer selects.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    slot_reg <= '0;
                end else if (push && (wr_ptr_reg == ptr_t'(gi))) begin
                    slot_reg <= bus.mem_readdata;
                end
            end

            assign slot_data[gi] = slot_reg;
        end
    endgenerate

    // Transfer FSM plus read issue, FIFO pointer and packet position bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            issue_left_reg <= '0;
            len_reg        <= '0;
            out_idx_reg    <= '0;
            inflight_reg   <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            inflight_reg <= issue;

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + ptr_t'(1);
                out_idx_reg <= out_idx_reg + len_t'(1);
            end
            unique case ({push, pop})
                2'b10:   count_reg <= count_reg + cnt_t'(1);
                2'b01:   count_reg <= count_reg - cnt_t'(1);
                default: count_reg <= count_reg;
            endcase

            // Address wraps naturally at the top of the memory.
            if (issue) begin
                addr_reg       <= addr_reg + addr_t'(1);
                issue_left_reg <= issue_left_reg - len_t'(1);
            end

            unique case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        addr_reg       <= bus.base_addr;
                        len_reg        <= bus.length;
                        issue_left_reg <= bus.length;
                        out_idx_reg    <= '0;
                        busy_reg       <= 1'b1;
                        if (bus.length == '0) begin
                            state_reg <= FIN;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue && (issue_left_reg == len_t'(1))) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && eop) begin
                        state_reg <= FIN;
                        done_reg  <= 1'b1;
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy             = busy_reg;
    assign bus.done             = done_reg;
    assign bus.mem_address      = addr_reg;
    assign bus.mem_chipselect   = issue;
    assign bus.mem_clken        = 1'b1;
    assign bus.mem_write        = 1'b0;
    assign bus.st_data          = slot_data[rd_ptr_reg];
    assign bus.st_valid         = fifo_valid;
    assign bus.st_startofpacket = sop;
    assign bus.st_endofpacket   = eop;

endmodule

// File: tb/tb_onchip_mem_byte_streamer.sv
// Scoreboard bench for onchip_mem_byte_streamer: directed transfers push the
// expected read addresses and stream beats into queues; a negedge monitor
// pops and compares whenever the DUT issues a read or hands over a byte.
module tb_onchip_mem_byte_streamer;
    localparam int ADDR_W = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    onchip_mem_byte_streamer_if #(.ADDR_W(ADDR_W)) bus ();

    onchip_mem_byte_streamer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Memory model: each location holds the low byte of its own address.
    always @(posedge clk) begin
        if (bus.mem_chipselect) bus.mem_readdata <= bus.mem_address[7:0];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [9:0]  beat_q [$];   // {sop, eop, data}
    logic [15:0] addr_q [$];

    int issued = 0, accepted = 0, max_out = 0;
    int first_valid_cyc = -1, first_acc_cyc = -1, last_acc_cyc = -1, last_eop_cyc = -1;
    bit stalled_prev = 1'b0;
    logic [10:0] prev_beat = '0;
    logic [10:0] cur_beat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares read addresses and accepted beats against the queues.
    always @(negedge clk) begin
        if (!reset_n) begin
            stalled_prev = 1'b0;
            issued = 0;
            accepted = 0;
        end else begin
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (bus.mem_chipselect) begin
                if (addr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_read: mem_address 0x%h, no read expected", bus.mem_address);
                end else begin
                    check("mem_address", 32'(bus.mem_address), 32'(addr_q.pop_front()));
                end
                issued++;
            end
            cur_beat = {bus.st_valid, bus.st_startofpacket, bus.st_endofpacket, bus.st_data};
            if (stalled_prev) check("stall_hold", 32'(cur_beat), 32'(prev_beat));
            if (bus.st_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.st_valid && bus.st_ready) begin
                if (beat_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_byte: data 0x%h, no byte expected", bus.st_data);
                end else begin
                    check("st_beat", 32'(cur_beat[9:0]), 32'(beat_q.pop_front()));
                end
                accepted++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                if (bus.st_endofpacket) last_eop_cyc = cyc;
            end
            stalled_prev = bus.st_valid && !bus.st_ready;
            prev_beat = cur_beat;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},   32'(bus.busy), 0);
        check({tag, "_done"},   32'(bus.done), 0);
        check({tag, "_valid"},  32'(bus.st_valid), 0);
        check({tag, "_sop"},    32'(bus.st_startofpacket), 0);
        check({tag, "_eop"},    32'(bus.st_endofpacket), 0);
        check({tag, "_cs"},     32'(bus.mem_chipselect), 0);
        check({tag, "_addr"},   32'(bus.mem_address), 0);
        check({tag, "_data"},   32'(bus.st_data), 0);
        check({tag, "_write"},  32'(bus.mem_write), 0);
        check({tag, "_clken"},  32'(bus.mem_clken), 1);
    endtask

    task automatic queue_expect(input logic [15:0] base, input int len);
        logic [15:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + 16'(i);
            addr_q.push_back(a);
            beat_q.push_back({(i == 0), (i == len - 1), a[7:0]});
        end
    endtask

    // mode 0: st_ready held high; mode 1: st_ready pattern 1,0,0,1,0,0,...
    // poke: issue a second start while the first transfer is busy.
    task automatic run_xfer(input logic [15:0] base, input int len, input int mode,
                            input bit poke, input bit timing);
        int start_cyc;
        int done_cyc;
        bit got;
        queue_expect(base, len);
        first_valid_cyc = -1;
        first_acc_cyc = -1;
        last_acc_cyc = -1;
        last_eop_cyc = -1;
        max_out = 0;
        done_cyc = 0;
        got = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.length = 17'(len);
        bus.st_ready = 1'b1;
        start_cyc = cyc;
        for (int k = 0; k < 300 && !got; k++) begin
            @(posedge clk); #1;
            bus.start = poke && (k == 1);
            if (poke && k == 1) begin
                bus.base_addr = 16'h0055;
                bus.length = 17'd3;
            end
            bus.st_ready = (mode == 0) || (k % 3 == 2);
            @(negedge clk);
            if (k == 0) check("busy_high", 32'(bus.busy), 1);
            if (bus.done) begin
                got = 1'b1;
                done_cyc = cyc;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done, expected done within 300 cycles (base 0x%h len %0d)", base, len);
        end else begin
            if (len > 0) check("done_after_eop", 32'(done_cyc - last_eop_cyc), 1);
            if (timing) begin
                check("first_valid_latency", 32'(first_valid_cyc - start_cyc), 3);
                check("burst_span", 32'(last_acc_cyc - first_acc_cyc), 32'(len - 1));
            end
            check("queues_drained", 32'(beat_q.size() + addr_q.size()), 0);
            @(negedge clk);
            check("done_one_cycle", 32'(bus.done), 0);
            check("busy_clear", 32'(bus.busy), 0);
        end
        $display("[TB] xfer base=0x%h len=%0d ready_mode=%0d done_cycle=%0d", base, len, mode, done_cyc);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.length = '0;
        bus.st_ready = 1'b0;
        #1;
        check_reset_vals("por");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        run_xfer(16'h0010, 4, 0, 1'b0, 1'b1);   // basic packet
        run_xfer(16'hFFFE, 4, 0, 1'b0, 1'b1);   // address wrap
        run_xfer(16'h0040, 8, 1, 1'b0, 1'b0);   // back-pressure
        check("max_outstanding_gt4", 32'(max_out > 4), 0);
        run_xfer(16'h0000, 0, 0, 1'b0, 1'b0);   // zero length
        run_xfer(16'h0077, 1, 0, 1'b1, 1'b1);   // single byte, ignored restart

        // Abort a 16-byte transfer with reset while reads are in flight.
        queue_expect(16'h0100, 16);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.base_addr = 16'h0100;
        bus.length = 17'd16;
        bus.st_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_reset_vals("abort");
        beat_q.delete();
        addr_q.delete();
        $display("[TB] xfer base=0x0100 len=16 aborted by reset");
        repeat (2) @(posedge clk);
        check("abort_no_done", 32'(bus.done), 0);
        #1 reset_n = 1'b1;
        run_xfer(16'h0020, 2, 0, 1'b0, 1'b1);   // clean transfer after abort

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
